// File: rtl/data_mem_pkg.sv
// Shared definitions for the data-memory responder: size encodings, FSM
// states and the request error check.
package data_mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } stateT;

  // Flags illegal size, misalignment and addresses beyond the storage.
  function automatic logic reqError(input logic [1:0]  size,
                                    input logic [31:0] addr,
                                    input int unsigned depthWords);
    logic [33:0] limit;
    logic        err;
    limit = 34'(depthWords) << 2;
    err   = 1'b0;
    if (size == SIZE_ILL)                          err = 1'b1;
    if ((size == SIZE_HALF) && addr[0])            err = 1'b1;
    if ((size == SIZE_WORD) && (addr[1:0] != 2'b00)) err = 1'b1;
    if (34'(addr) >= limit)                        err = 1'b1;
    return err;
  endfunction

endpackage

// File: rtl/data_mem_responder_lane.sv
// byte_lane_align: little-endian lane steering for stores (merge + lane
// enables) and loads (lane extract + sign/zero extension).
module byte_lane_align
  import data_mem_pkg::*;
(
  input  logic [31:0] storedWord,
  input  logic [31:0] wdata,
  input  logic [1:0]  laneAddr,
  input  logic [1:0]  size,
  input  logic        isSigned,
  output logic [31:0] mergedWord,
  output logic [3:0]  laneWe,
  output logic [31:0] loadData
);

  logic [31:0] replData;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // Replicate store data across lanes, pick enabled lanes, extend loads.
  always_comb begin
    laneWe   = 4'b0000;
    replData = wdata;
    loadData = '0;
    byteSel  = storedWord[{laneAddr, 3'b000} +: 8];
    halfSel  = laneAddr[1] ? storedWord[31:16] : storedWord[15:0];
    case (size)
      SIZE_BYTE: begin
        laneWe   = 4'b0001 << laneAddr;
        replData = {4{wdata[7:0]}};
        loadData = {{24{isSigned & byteSel[7]}}, byteSel};
      end
      SIZE_HALF: begin
        laneWe   = laneAddr[1] ? 4'b1100 : 4'b0011;
        replData = {2{wdata[15:0]}};
        loadData = {{16{isSigned & halfSel[15]}}, halfSel};
      end
      SIZE_WORD: begin
        laneWe   = 4'b1111;
        replData = wdata;
        loadData = storedWord;
      end
      default: begin
        laneWe   = 4'b0000;
        loadData = '0;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      mergedWord[8*i +: 8] = laneWe[i] ? replData[8*i +: 8] : storedWord[8*i +: 8];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: responder end of the data-memory load/store port.
// One request at a time, programmable wait states, byte/half/word access.
// Optional macro DATA_MEM_POSTED_WRITE_EN: error-free stores complete
// without a response phase.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 4;

  stateT             state, stateNext;
  logic [CNT_W-1:0]  waitCnt, waitCntNext;
  logic              reqReadyNext, rspValidNext, rspErrNext;
  logic [31:0]       rspRdataNext;

  logic              capWrite, capSigned;
  logic [1:0]        capSize;
  logic [31:0]       capAddr, capWdata;

  logic [31:0]       mem [DEPTH_WORDS];
  logic [IDX_W-1:0]  wordIdx;
  logic [31:0]       storedWord, mergedWord, loadData;
  logic [3:0]        laneWe;
  logic              accept, accessNow, capErr, commitStore;

  assign accept      = req_valid & req_ready;
  // The counter is loaded with WAIT_CYCLES; its final (zero) cycle is the access cycle.
  assign accessNow   = (state == WAIT) && (waitCnt == '0);
  assign capErr      = reqError(capSize, capAddr, DEPTH_WORDS);
  assign wordIdx     = capAddr[IDX_W+1:2];
  assign storedWord  = mem[wordIdx];
  assign commitStore = accessNow & capWrite & ~capErr;

  byte_lane_align uLane (
    .storedWord (storedWord),
    .wdata      (capWdata),
    .laneAddr   (capAddr[1:0]),
    .size       (capSize),
    .isSigned   (capSigned),
    .mergedWord (mergedWord),
    .laneWe     (laneWe),
    .loadData   (loadData)
  );

  // Next-state and next-output decode.
  always_comb begin
    stateNext    = state;
    waitCntNext  = waitCnt;
    rspRdataNext = rsp_rdata;
    rspErrNext   = rsp_err;
    case (state)
      IDLE: begin
        if (accept) begin
          stateNext   = WAIT;
          waitCntNext = CNT_W'(WAIT_CYCLES);
        end
      end
      WAIT: begin
        if (waitCnt == '0) begin
          stateNext    = RESP;
          rspErrNext   = capErr;
          rspRdataNext = (capErr | capWrite) ? 32'h0 : loadData;
`ifdef DATA_MEM_POSTED_WRITE_EN
          if (capWrite && !capErr) stateNext = IDLE;
`endif
        end else begin
          waitCntNext = waitCnt - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    reqReadyNext = (stateNext == IDLE);
    rspValidNext = (stateNext == RESP);
  end

  // State, registered outputs and request capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      waitCnt   <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      capWrite  <= 1'b0;
      capSize   <= SIZE_BYTE;
      capSigned <= 1'b0;
      capAddr   <= '0;
      capWdata  <= '0;
    end else begin
      state     <= stateNext;
      waitCnt   <= waitCntNext;
      req_ready <= reqReadyNext;
      rsp_valid <= rspValidNext;
      rsp_rdata <= rspRdataNext;
      rsp_err   <= rspErrNext;
      if (accept) begin
        capWrite  <= req_write;
        capSize   <= req_size;
        capSigned <= req_signed;
        capAddr   <= req_addr;
        capWdata  <= req_wdata;
      end
    end
  end

  // Storage write, lane-enabled; contents are not reset.
  always_ff @(posedge clk) begin
    if (commitStore) begin
      for (int i = 0; i < 4; i++) begin
        if (laneWe[i]) mem[wordIdx][8*i +: 8] <= mergedWord[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: stimulus pushes expected
// responses, a monitor pops and compares on each response handshake.
module tb_data_mem_responder;

  localparam int unsigned W = 2;
`ifdef DATA_MEM_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic        clk, rst;
  logic        reqValid, reqReady, reqWrite, reqSigned;
  logic [1:0]  reqSize;
  logic [31:0] reqAddr, reqWdata;
  logic        rspValid, rspReady, rspErr;
  logic [31:0] rspRdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } expT;

  expT expQ[$];
  int  checks   = 0;
  int  failures = 0;
  bit  lastPosted;

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (reqValid),
    .req_ready (reqReady),
    .req_write (reqWrite),
    .req_size  (reqSize),
    .req_signed(reqSigned),
    .req_addr  (reqAddr),
    .req_wdata (reqWdata),
    .rsp_valid (rspValid),
    .rsp_ready (rspReady),
    .rsp_rdata (rspRdata),
    .rsp_err   (rspErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: each response handshake pops one expectation.
  always @(negedge clk) begin
    if (rst && rspValid && rspReady) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp actual rdata=0x%08h err=%0b required=no response",
                 rspRdata, rspErr);
      end else begin
        expT e;
        e = expQ.pop_front();
        chk("rsp_rdata", rspRdata, e.rdata);
        chk("rsp_err", 32'(rspErr), 32'(e.err));
      end
    end
  end

  // Waits for req_ready, presents one request, returns #1 after the accepting edge.
  task automatic startReq(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] expD, input logic expE, input bit push);
    expT e;
    for (int i = 0; i < 50 && !reqReady; i++) begin
      @(posedge clk); #1;
    end
    if (!reqReady) begin
      checks++; failures++;
      $display("FAIL req_ready_timeout actual=0 required=1");
    end
    reqValid = 1'b1; reqWrite = w; reqSize = sz; reqSigned = sg;
    reqAddr = addr; reqWdata = wd;
    lastPosted = POSTED && w && !expE;
    if (push && !lastPosted) begin
      e.rdata = expD; e.err = expE;
      expQ.push_back(e);
    end
    @(posedge clk); #1;
    reqValid = 1'b0;
    reqWrite = ~w; reqSize = ~sz; reqSigned = ~sg;
    reqAddr = 32'h5A5A_5A5A; reqWdata = 32'hFFFF_FFFF;
  endtask

  // Checks latency from acceptance, then optionally waits for the monitor to drain.
  task automatic waitRsp(input bit drain);
    int n;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      n++;
      if (lastPosted ? reqReady : rspValid) break;
    end
    chk(lastPosted ? "posted_latency" : "rsp_latency", 32'(n), 32'(W + 1));
    if (lastPosted) chk("posted_no_rsp", 32'(rspValid), 32'd0);
    if (drain) begin
      for (int i = 0; i < 40 && expQ.size() > 0; i++) begin
        @(posedge clk); #1;
      end
      if (expQ.size() > 0) begin
        checks++; failures++;
        $display("FAIL rsp_timeout actual pending=%0d required=0", expQ.size());
        expQ.delete();
      end
    end
  endtask

  task automatic doReq(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] expD, input logic expE);
    startReq(w, sz, sg, addr, wd, expD, expE, 1'b1);
    waitRsp(1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'b00; reqSigned = 1'b0;
    reqAddr = '0; reqWdata = '0; rspReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", 32'(reqReady), 32'd1);
    chk("reset_rsp_valid", 32'(rspValid), 32'd0);
    chk("reset_rsp_rdata", rspRdata, 32'd0);
    chk("reset_rsp_err", 32'(rspErr), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Word store then load
    doReq(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
    doReq(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // Byte lanes and extension
    doReq(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, 32'h0, 1'b0);
    doReq(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_0080, 32'h0, 1'b0);
    doReq(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h8022_3344, 1'b0);
    doReq(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'hFFFF_FF80, 1'b0);
    doReq(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h0000_0080, 1'b0);
    doReq(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'hFFFF_8022, 1'b0);
    doReq(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'h0000_3344, 1'b0);
    doReq(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'h0000_0033, 1'b0);
    doReq(1'b1, 2'b01, 1'b0, 32'h12, 32'h1234_BEEF, 32'h0, 1'b0);
    doReq(1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 32'hBEEF_3344, 1'b0);

    // Errors leave storage untouched
    doReq(1'b1, 2'b10, 1'b0, 32'h04, 32'h5566_7788, 32'h0, 1'b0);
    doReq(1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 32'h0, 1'b1);
    doReq(1'b1, 2'b01, 1'b0, 32'h05, 32'h0000_FFFF, 32'h0, 1'b1);
    doReq(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 32'h5566_7788, 1'b0);
    doReq(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1);
    doReq(1'b1, 2'b11, 1'b0, 32'h10, 32'h1234_5678, 32'h0, 1'b1);
    doReq(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hBEEF_3344, 1'b0);
    doReq(1'b1, 2'b10, 1'b0, 32'h00, 32'hA5A5_A5A5, 32'h0, 1'b0);
    doReq(1'b1, 2'b10, 1'b0, 32'h1000, 32'hFFFF_FFFF, 32'h0, 1'b1);
    doReq(1'b0, 2'b00, 1'b0, 32'h1003, 32'h0, 32'h0, 1'b1);
    doReq(1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 32'hA5A5_A5A5, 1'b0);
    // Last in-range word
    doReq(1'b1, 2'b10, 1'b0, 32'hFFC, 32'h0BAD_CAFE, 32'h0, 1'b0);
    doReq(1'b0, 2'b00, 1'b1, 32'hFFF, 32'h0, 32'h0000_000B, 1'b0);

    // Backpressure: response held, no new acceptance until after rsp_ready
    rspReady = 1'b0;
    startReq(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 32'h5566_7788, 1'b0, 1'b1);
    waitRsp(1'b0);
    reqValid = 1'b1; reqWrite = 1'b0; reqSize = 2'b01; reqSigned = 1'b0;
    reqAddr = 32'h12; reqWdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_rsp_valid", 32'(rspValid), 32'd1);
      chk("bp_rsp_rdata", rspRdata, 32'h5566_7788);
      chk("bp_req_ready", 32'(reqReady), 32'd0);
    end
    begin
      expT e;
      e.rdata = 32'h0000_BEEF; e.err = 1'b0;
      expQ.push_back(e);
    end
    rspReady = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_rsp_valid", 32'(rspValid), 32'd0);
    chk("bp_release_req_ready", 32'(reqReady), 32'd1);
    @(posedge clk); #1;
    reqValid = 1'b0;
    chk("bp_accepted", 32'(reqReady), 32'd0);
    lastPosted = 1'b0;
    waitRsp(1'b1);

    // Reset during WAIT of a store: never committed
    doReq(1'b1, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);
    startReq(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst_req_ready", 32'(reqReady), 32'd1);
    chk("midrst_rsp_valid", 32'(rspValid), 32'd0);
    chk("midrst_rsp_rdata", rspRdata, 32'd0);
    chk("midrst_rsp_err", 32'(rspErr), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    doReq(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
